pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised inter-stage pipeline register for the PCPU datapath. It replaces the fixed per-stage register banks (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. It carries a control word plus NCH data channels per stage, and adds a valid/ready handshake, back-pressure, and cause-selective squash. An optional skid buffer breaks the combinational ready path.

## Interface
Parameters:
- CTRL_W, 32, control-signal word width (decoded opcode fields, MemRead/MemWrite/BEOp, ...)
- DATA_W, 32, width of one data channel
- NCH, 6, number of data channels (NPC, ALUOut, rt, EXT, RD, CD for the EX/MEM instance)
- CAUSE_W, 2, exception-cause width
- KILL_MASK, 4'b1000, bit k set means cause k squashes this stage (2^CAUSE_W bits; default squashes on overflow, cause 3)
- CNT_W, 16, squash-counter width

Ports:
- clk, in, 1, clock; all state changes on the rising edge
- rst, in, 1, synchronous, active-low reset
- in_valid_i, in, 1, upstream beat valid
- in_ready_o, out, 1, stage can accept a beat
- ctrl_i, in, CTRL_W, incoming control word
- data_i, in, NCH*DATA_W, incoming channels; channel k is at [k*DATA_W +: DATA_W]
- flush_i, in, 1, flush request from the exception unit
- cause_i, in, CAUSE_W, cause qualifying flush_i
- out_valid_o, out, 1, held beat valid
- out_ready_i, in, 1, downstream accepts the beat
- ctrl_o, out, CTRL_W, held control word
- data_o, out, NCH*DATA_W, held channels
- squash_cnt_o, out, CNT_W, saturating count of squashed beats

## Operation
- Transfers:
  - An upstream transfer occurs when in_valid_i && in_ready_o.
  - A downstream transfer occurs when out_valid_o && out_ready_i.
- squash = flush_i && KILL_MASK[cause_i].
- Normal beat: ctrl_i and data_i are captured; out_valid_o is set.
- Squash cycle:
  - Every valid entry (main register and skid register) is invalidated and its ctrl cleared to 0; data is left unchanged.
  - An incoming beat in the same cycle is consumed (in_ready_o is honoured) but stored as a bubble: ctrl=0, valid=0.
  - squash_cnt_o increments by the number of valid beats destroyed (held beats plus the incoming beat, 0..3). It saturates at 2^CNT_W-1 and never wraps.
- flush_i with a cause outside KILL_MASK has no effect.
- Priority: rst > squash > downstream/upstream transfer > hold.
- Hold: when out_valid_o && !out_ready_i, ctrl_o and data_o are stable and no beat is lost.
- A simultaneous downstream and upstream transfer replaces the held beat in the same edge (full throughput).
- Downstream logic must qualify ctrl_o with out_valid_o; ctrl_o is 0 whenever out_valid_o is 0 after a squash or reset.

## Timing
- Reset (rst=0 at an edge): out_valid_o=0, ctrl_o=0, data_o=0, squash_cnt_o=0, skid empty. While rst=0, in_ready_o=0.
- Latency: 1 cycle from an upstream transfer to out_valid_o.
- Without skid:
  - in_ready_o = !out_valid_o || out_ready_i (combinational from out_ready_i).
  - Depth 1.
- With skid:
  - in_ready_o is registered and equals "skid empty".
  - Depth 2.
  - A beat arriving while the main register is stalled goes to the skid register. The skid drains into the main register on the next downstream transfer.
  - Order is strictly FIFO.
- Reset asserted mid-stall discards all entries; no beat is emitted afterwards.
- Squash during a stall: out_valid_o falls on the next edge regardless of out_ready_i.

## Configuration
- Macro PIPE_STAGE_SKID_EN.
- Defined: a 2-entry skid buffer is present, in_ready_o is a register output, and there is no combinational path from out_ready_i to in_ready_o.
- Undefined: single register, combinational ready pass-through, and no skid storage is synthesised.
- Squash and counter behaviour are identical in both builds.

## Structure
- Shared package pcpu_pipe_pkg holds:
  - cause encodings: CAUSE_NONE=0, CAUSE_INT=1, CAUSE_SYSCALL=2, CAUSE_OVF=3
  - default KILL_MASK constants per stage
  - the control-word bit positions: BEOp [9:7], MemRead [10], MemWrite [11]
- One sub-module, pipe_stage_slot: a single valid+ctrl+data register with load/clear. It is instantiated once for the main register and once for the skid register (the skid instance under the macro).
- The counter and handshake logic stay in the top module.

## Test plan
- Reset, then in_valid_i=1, ctrl_i=32'h0000_0C80, channel0=32'h0000_3004, out_ready_i=1. Required: the next cycle shows out_valid_o=1, ctrl_o=32'h0000_0C80, channel0=32'h0000_3004, with MemWrite=1 and BEOp=3'b001.
- Stream beats A, B, C with out_ready_i=0 for 3 cycles, then 1. Required: A stays stable during the stall and the outputs are A, B, C in order, with no loss or duplication. In the skid build, in_ready_o drops only after B is held.
- flush_i=1, cause_i=2'b11 while beat D enters and beat C is held. Required: the next cycle shows out_valid_o=0, ctrl_o=0, squash_cnt_o=2.
- flush_i=1, cause_i=2'b01 with the default mask. Required: no squash; the beat passes unchanged and squash_cnt_o is unchanged.
- Preload squash_cnt_o to 16'hFFFE, then squash 2 beats. Required: squash_cnt_o=16'hFFFF and it stays there.
- Assert rst=0 mid-stall with two beats held. Required: the next edge shows out_valid_o=0 and in_ready_o=0 while reset is held; the first beat after reset release is a fresh beat.

Source files
------------

// File: rtl/pcpu_pipe_pkg.sv
// Shared PCPU pipeline definitions: exception causes, per-stage squash masks and
// control-word field positions used by the inter-stage registers and their consumers.
package pcpu_pipe_pkg;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_INT     = 2'd1,
        CAUSE_SYSCALL = 2'd2,
        CAUSE_OVF     = 2'd3
    } cause_e;

    // Bit k set means cause k squashes the beats held in that stage.
    localparam logic [3:0] KILL_MASK_IFID  = 4'b1110;
    localparam logic [3:0] KILL_MASK_IDEX  = 4'b1110;
    localparam logic [3:0] KILL_MASK_EXMEM = 4'b1000;
    localparam logic [3:0] KILL_MASK_MEMWB = 4'b0000;

    localparam int CTRL_BEOP_LSB  = 7;
    localparam int CTRL_BEOP_MSB  = 9;
    localparam int CTRL_MEMREAD   = 10;
    localparam int CTRL_MEMWRITE  = 11;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready stream carrying one pipeline beat: a control word plus NCH data channels.
interface pipe_stage_reg_if #(
    parameter int CTRL_W = 32,
    parameter int DATA_W = 32,
    parameter int NCH    = 6
);

    logic                    valid;
    logic                    ready;
    logic [CTRL_W-1:0]       ctrl;
    logic [NCH*DATA_W-1:0]   data;

    modport master (output valid, output ctrl, output data, input ready);
    modport slave  (input valid, input ctrl, input data, output ready);

endinterface

// File: rtl/pipe_stage_slot.sv
// One pipeline entry: valid bit, control word and data. Kill drops the beat and zeroes
// its control word but leaves the data untouched.
module pipe_stage_slot #(
    parameter int CTRL_W = 32,
    parameter int WIDTH  = 192
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              kill,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic [WIDTH-1:0]  data_d,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [WIDTH-1:0]  data
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (kill) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= ctrl_d;
            data  <= data_d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake and cause-selective squash.
// Define PIPE_STAGE_SKID_EN to add a skid entry and take in_ready from a register.
module pipe_stage_reg
    import pcpu_pipe_pkg::*;
#(
    parameter int CTRL_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NCH     = 6,
    parameter int CAUSE_W = 2,
    parameter logic [(2**CAUSE_W)-1:0] KILL_MASK = KILL_MASK_EXMEM,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_stage_reg_if.slave      up,
    pipe_stage_reg_if.master     dn,
    input  logic                 flush_i,
    input  logic [CAUSE_W-1:0]   cause_i,
    output logic [CNT_W-1:0]     squash_cnt_o
);

    localparam int DW = NCH * DATA_W;

    logic              squash;
    logic              up_xfer;
    logic              dn_xfer;
    logic [1:0]        killed;
    logic              m_load;
    logic              m_kill;
    logic              m_valid;
    logic [CTRL_W-1:0] m_ctrl;
    logic [DW-1:0]     m_data;
    logic [CTRL_W-1:0] m_ctrl_d;
    logic [DW-1:0]     m_data_d;
    logic [CNT_W:0]    cnt_sum;

    assign squash   = flush_i && KILL_MASK[cause_i];
    assign up_xfer  = up.valid && up.ready;
    assign dn_xfer  = m_valid && dn.ready;
    assign dn.valid = m_valid;
    assign dn.ctrl  = m_ctrl;
    assign dn.data  = m_data;

    pipe_stage_slot #(.CTRL_W(CTRL_W), .WIDTH(DW)) u_main (
        .clk(clk), .rst(rst), .load(m_load), .kill(m_kill),
        .ctrl_d(m_ctrl_d), .data_d(m_data_d),
        .valid(m_valid), .ctrl(m_ctrl), .data(m_data)
    );

`ifdef PIPE_STAGE_SKID_EN
    logic              s_load;
    logic              s_kill;
    logic              s_valid;
    logic [CTRL_W-1:0] s_ctrl;
    logic [DW-1:0]     s_data;

    // The skid entry is only ever occupied behind a stalled main entry.
    assign up.ready = rst && !s_valid;

    pipe_stage_slot #(.CTRL_W(CTRL_W), .WIDTH(DW)) u_skid (
        .clk(clk), .rst(rst), .load(s_load), .kill(s_kill),
        .ctrl_d(up.ctrl), .data_d(up.data),
        .valid(s_valid), .ctrl(s_ctrl), .data(s_data)
    );

    always_comb begin
        m_load   = 1'b0;
        m_kill   = 1'b0;
        s_load   = 1'b0;
        s_kill   = 1'b0;
        m_ctrl_d = up.ctrl;
        m_data_d = up.data;
        killed   = 2'd0;
        if (squash) begin
            m_kill = 1'b1;
            s_kill = 1'b1;
            killed = 2'(m_valid) + 2'(s_valid) + 2'(up_xfer);
        end else if (dn_xfer) begin
            if (s_valid) begin
                m_load   = 1'b1;
                m_ctrl_d = s_ctrl;
                m_data_d = s_data;
                s_kill   = 1'b1;
            end else if (up_xfer) begin
                m_load = 1'b1;
            end else begin
                m_kill = 1'b1;
            end
        end else if (up_xfer) begin
            if (m_valid) s_load = 1'b1;
            else         m_load = 1'b1;
        end
    end
`else
    assign up.ready = rst && (!m_valid || dn.ready);

    always_comb begin
        m_load   = 1'b0;
        m_kill   = 1'b0;
        m_ctrl_d = up.ctrl;
        m_data_d = up.data;
        killed   = 2'd0;
        if (squash) begin
            m_kill = 1'b1;
            killed = 2'(m_valid) + 2'(up_xfer);
        end else if (up_xfer) begin
            m_load = 1'b1;
        end else if (dn_xfer) begin
            m_kill = 1'b1;
        end
    end
`endif

    // Squash counter saturates at all-ones instead of wrapping.
    assign cnt_sum = {1'b0, squash_cnt_o} + (CNT_W+1)'(killed);

    always_ff @(posedge clk) begin
        if (!rst) begin
            squash_cnt_o <= '0;
        end else if (squash) begin
            if (cnt_sum[CNT_W]) squash_cnt_o <= '1;
            else                squash_cnt_o <= cnt_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: a queue-based model checked every cycle plus
// hand-computed literal checks. Honours PIPE_STAGE_SKID_EN for the expected depth.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam int         CNT_MAX = 65535;
    localparam logic [3:0] MASK    = 4'b1000;

    typedef struct {
        logic [31:0]  ctrl;
        logic [191:0] data;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [1:0]  cause;
    logic [15:0] squash_cnt;

    int    checks = 0;
    int    errors = 0;
    logic  chk_en = 1'b0;
    beat_t q[$];
    int    mcnt = 0;
    logic  zc = 1'b1;

    pipe_stage_reg_if #(.CTRL_W(32), .DATA_W(32), .NCH(6)) up_if ();
    pipe_stage_reg_if #(.CTRL_W(32), .DATA_W(32), .NCH(6)) dn_if ();

    pipe_stage_reg #(
        .CTRL_W(32), .DATA_W(32), .NCH(6), .CAUSE_W(2), .KILL_MASK(4'b1000), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .up(up_if), .dn(dn_if),
        .flush_i(flush), .cause_i(cause), .squash_cnt_o(squash_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [191:0] mk_data(input logic [31:0] d0);
        logic [191:0] r;
        for (int k = 0; k < 6; k++) r[k*32 +: 32] = d0 + 32'(k) * 32'h0101_0000;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of inputs, then step past the capturing edge.
    task automatic applyStimulus(input logic v, input logic [31:0] c, input logic [31:0] d0,
                                 input logic fl, input logic [1:0] cs, input logic ordy);
        up_if.valid = v;
        up_if.ctrl  = c;
        up_if.data  = mk_data(d0);
        flush       = fl;
        cause       = cs;
        dn_if.ready = ordy;
        @(posedge clk);
        #1;
    endtask

    // Reference behaviour: a FIFO of up to DEPTH beats plus a saturating squash count.
    always @(posedge clk) begin
        logic rdy, upx;
        int   n;
        if (!rst) begin
            q.delete();
            mcnt = 0;
            zc   = 1'b1;
        end else begin
            rdy = (q.size() < DEPTH) || (DEPTH == 1 && dn_if.ready);
            upx = up_if.valid && rdy;
            if (flush && MASK[cause]) begin
                n    = q.size() + int'(upx);
                mcnt = (mcnt + n > CNT_MAX) ? CNT_MAX : mcnt + n;
                q.delete();
                zc   = 1'b1;
            end else begin
                if (q.size() > 0 && dn_if.ready) void'(q.pop_front());
                if (upx) q.push_back('{ctrl: up_if.ctrl, data: up_if.data});
                if (q.size() > 0) zc = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("in_ready", 256'(up_if.ready),
                        256'(rst && ((q.size() < DEPTH) || (DEPTH == 1 && dn_if.ready))));
            checkOutput("out_valid", 256'(dn_if.valid), 256'(q.size() > 0));
            if (q.size() > 0) begin
                checkOutput("ctrl_o", 256'(dn_if.ctrl), 256'(q[0].ctrl));
                checkOutput("data_o", 256'(dn_if.data), 256'(q[0].data));
            end else if (zc) begin
                checkOutput("ctrl_o_cleared", 256'(dn_if.ctrl), 256'(0));
            end
            checkOutput("squash_cnt", 256'(squash_cnt), 256'(mcnt));
        end
    end

    initial begin
        logic [31:0] beats [3];
        logic [7:0]  opat;
        logic [31:0] emitted[$];
        int          idx;

        rst = 1'b0;
        up_if.valid = 1'b0;
        up_if.ctrl  = '0;
        up_if.data  = '0;
        flush = 1'b0;
        cause = 2'b00;
        dn_if.ready = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
        chk_en = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
        checkOutput("rst_valid", 256'(dn_if.valid), 256'(0));
        checkOutput("rst_ctrl", 256'(dn_if.ctrl), 256'(0));
        checkOutput("rst_data", 256'(dn_if.data), 256'(0));
        checkOutput("rst_cnt", 256'(squash_cnt), 256'(0));
        checkOutput("rst_ready", 256'(up_if.ready), 256'(0));

        rst = 1'b1;
        applyStimulus(1'b1, 32'h0000_0C80, 32'h0000_3004, 1'b0, 2'b00, 1'b1);
        checkOutput("first_valid", 256'(dn_if.valid), 256'(1));
        checkOutput("first_ctrl", 256'(dn_if.ctrl), 256'(32'h0000_0C80));
        checkOutput("first_ch0", 256'(dn_if.data[31:0]), 256'(32'h0000_3004));
        checkOutput("first_memwrite", 256'(dn_if.ctrl[11]), 256'(1));
        checkOutput("first_beop", 256'(dn_if.ctrl[9:7]), 256'(3'b001));
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b1);

        // A, B, C streamed against three stalled cycles.
        beats = '{32'h0000_0A01, 32'h0000_0B02, 32'h0000_0C03};
        opat  = 8'b1111_1000;
        idx   = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            up_if.valid = (idx < 3);
            up_if.ctrl  = (idx < 3) ? beats[idx] : 32'h0;
            up_if.data  = mk_data(up_if.ctrl ^ 32'h1234_0000);
            dn_if.ready = opat[cyc];
            @(negedge clk);
            if (dn_if.valid && dn_if.ready) emitted.push_back(dn_if.ctrl);
            if (up_if.valid && up_if.ready) idx++;
            @(posedge clk);
            #1;
            if (cyc == 2) checkOutput("stall_hold_A", 256'(dn_if.ctrl), 256'(32'h0000_0A01));
        end
        checkOutput("stream_count", 256'(emitted.size()), 256'(3));
        if (emitted.size() == 3) begin
            checkOutput("stream_A", 256'(emitted[0]), 256'(32'h0000_0A01));
            checkOutput("stream_B", 256'(emitted[1]), 256'(32'h0000_0B02));
            checkOutput("stream_C", 256'(emitted[2]), 256'(32'h0000_0C03));
        end

        applyStimulus(1'b1, 32'h0000_0C0C, 32'h0000_C000, 1'b0, 2'b00, 1'b0);
        applyStimulus(1'b1, 32'h0000_0D0D, 32'h0000_D000, 1'b1, 2'b11, 1'b1);
        checkOutput("squash_valid", 256'(dn_if.valid), 256'(0));
        checkOutput("squash_ctrl", 256'(dn_if.ctrl), 256'(0));
        checkOutput("squash_cnt2", 256'(squash_cnt), 256'(16'd2));

        applyStimulus(1'b1, 32'h0000_0E0E, 32'h0000_E000, 1'b1, 2'b01, 1'b1);
        checkOutput("nokill_valid", 256'(dn_if.valid), 256'(1));
        checkOutput("nokill_ctrl", 256'(dn_if.ctrl), 256'(32'h0000_0E0E));
        checkOutput("nokill_cnt", 256'(squash_cnt), 256'(16'd2));
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b1);

        // Drive the counter to 16'hFFFE one squashed bubble at a time.
        repeat (65532) applyStimulus(1'b1, 32'h0000_0001, 32'h0, 1'b1, 2'b11, 1'b0);
        checkOutput("preload_cnt", 256'(squash_cnt), 256'(16'hFFFE));
        applyStimulus(1'b1, 32'h0000_0F0F, 32'h0000_F000, 1'b0, 2'b00, 1'b0);
        applyStimulus(1'b1, 32'h0000_1010, 32'h0001_0000, 1'b1, 2'b11, 1'b1);
        checkOutput("sat_cnt", 256'(squash_cnt), 256'(16'hFFFF));
        applyStimulus(1'b1, 32'h0000_1111, 32'h0001_1000, 1'b1, 2'b11, 1'b1);
        checkOutput("sat_hold", 256'(squash_cnt), 256'(16'hFFFF));

        applyStimulus(1'b1, 32'h0000_2121, 32'h0002_1000, 1'b0, 2'b00, 1'b0);
        applyStimulus(1'b1, 32'h0000_2222, 32'h0002_2000, 1'b0, 2'b00, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b1, 32'h0000_2323, 32'h0002_3000, 1'b0, 2'b00, 1'b1);
        checkOutput("midrst_valid", 256'(dn_if.valid), 256'(0));
        checkOutput("midrst_ready", 256'(up_if.ready), 256'(0));
        checkOutput("midrst_cnt", 256'(squash_cnt), 256'(0));
        applyStimulus(1'b1, 32'h0000_2323, 32'h0002_3000, 1'b0, 2'b00, 1'b1);
        rst = 1'b1;
        applyStimulus(1'b1, 32'h0000_2424, 32'h0002_4000, 1'b0, 2'b00, 1'b1);
        checkOutput("fresh_ctrl", 256'(dn_if.ctrl), 256'(32'h0000_2424));
        checkOutput("fresh_ch0", 256'(dn_if.data[31:0]), 256'(32'h0002_4000));
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b1);
        checkOutput("drained_valid", 256'(dn_if.valid), 256'(0));
        repeat (3) applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b1);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
